// File: rtl/led_blink_ctrl_if.sv
// ----------------------------------------------------------------------------
// led_blink_ctrl_if
// Configuration write bus for led_blink_ctrl.
//   cfg_we     : single-cycle write strobe
//   cfg_ch     : target channel index
//   cfg_mode   : 00 OFF, 01 ON, 10 BLINK, 11 PWM
//   cfg_period : BLINK half-period in ticks / PWM duty in the low bits
// Modports: master drives the bus, slave (the LED controller) receives it.
// ----------------------------------------------------------------------------
interface led_blink_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             cfg_we;
   logic [4:0]       cfg_ch;
   logic [1:0]       cfg_mode;
   logic [CNT_W-1:0] cfg_period;

   modport master (output cfg_we, output cfg_ch, output cfg_mode, output cfg_period);
   modport slave  (input  cfg_we, input  cfg_ch, input  cfg_mode, input  cfg_period);
endinterface

// File: rtl/led_blink_ctrl.sv
// ----------------------------------------------------------------------------
// led_blink_ctrl
// Multi-channel LED driver: shared prescaler tick, per-channel OFF/ON/BLINK/PWM.
//   sys_clk   : system clock
//   sys_rst_n : asynchronous reset, active low
//   sync_i    : (LED_SYNC_EN only) clears prescaler, PWM counter and all
//               channel phases; modes and periods are kept
//   cfg       : configuration write bus (led_blink_ctrl_if.slave)
//   tick      : one-cycle pulse every TICK_DIV cycles
//   led       : registered LED drive, active high
// Optional feature macro: LED_SYNC_EN.
// ----------------------------------------------------------------------------
module led_blink_ctrl #(
   parameter int TICK_DIV = 100000,
   parameter int NCH      = 8,
   parameter int CNT_W    = 16,
   parameter int PWM_W    = 4
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst_n,
`ifdef LED_SYNC_EN
   input  logic                   sync_i,
`endif
   led_blink_ctrl_if.slave        cfg,
   output logic                   tick,
   output logic [NCH-1:0]         led
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_PWM   = 2'b11
   } mode_e;

   localparam int              PW        = $clog2(TICK_DIV);
   localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0]    r_presc;
   logic             r_tick;
   logic [PWM_W-1:0] r_pwm_cnt;
   mode_e            r_mode   [NCH];
   logic [CNT_W-1:0] r_period [NCH];
   logic [CNT_W-1:0] r_cnt    [NCH];
   logic [NCH-1:0]   r_blink;
   logic [NCH-1:0]   r_led;

   logic             w_sync;
   logic             w_wr_valid;
   logic [NCH-1:0]   w_hit;
   logic [CNT_W-1:0] w_last [NCH];

`ifdef LED_SYNC_EN
   assign w_sync = sync_i;
`else
   assign w_sync = 1'b0;
`endif

   assign w_wr_valid = cfg.cfg_we && ({27'd0, cfg.cfg_ch} < 32'(NCH));

   // Per-channel write hit and terminal count (P-1 with P = max(period,1)).
   always_comb begin
      for (int unsigned i = 0; i < NCH; i++) begin
         w_hit[i]  = w_wr_valid && (cfg.cfg_ch == 5'(i));
         w_last[i] = (r_period[i] == '0) ? '0 : r_period[i] - 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_presc   <= '0;
         r_tick    <= 1'b0;
         r_pwm_cnt <= '0;
         r_blink   <= '0;
         r_led     <= '0;
         for (int unsigned i = 0; i < NCH; i++) begin
            r_mode[i]   <= MODE_OFF;
            r_period[i] <= '0;
            r_cnt[i]    <= '0;
         end
      end else begin
         if (w_sync) begin
            r_presc   <= '0;
            r_tick    <= 1'b0;
            r_pwm_cnt <= '0;
         end else begin
            r_presc   <= (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
            r_tick    <= (r_presc == PRESC_MAX);
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
         end

         for (int unsigned i = 0; i < NCH; i++) begin
            if (w_hit[i]) begin
               r_mode[i]   <= mode_e'(cfg.cfg_mode);
               r_period[i] <= cfg.cfg_period;
            end

            // A write or sync on the tick cycle wins: phase restarts, no toggle.
            if (w_sync || w_hit[i]) begin
               r_cnt[i]   <= '0;
               r_blink[i] <= 1'b0;
            end else if (r_tick && (r_mode[i] == MODE_BLINK)) begin
               if (r_cnt[i] == w_last[i]) begin
                  r_cnt[i]   <= '0;
                  r_blink[i] <= ~r_blink[i];
               end else begin
                  r_cnt[i]   <= r_cnt[i] + 1'b1;
               end
            end

            case (r_mode[i])
               MODE_OFF:   r_led[i] <= 1'b0;
               MODE_ON:    r_led[i] <= 1'b1;
               MODE_BLINK: r_led[i] <= r_blink[i];
               MODE_PWM:   r_led[i] <= (r_pwm_cnt < r_period[i][PWM_W-1:0]);
               default:    r_led[i] <= 1'b0;
            endcase
         end
      end
   end

   assign tick = r_tick;
   assign led  = r_led;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// ----------------------------------------------------------------------------
// tb_led_blink_ctrl
// Directed bench for led_blink_ctrl with TICK_DIV=4, NCH=8, CNT_W=16, PWM_W=4.
// Inputs change and outputs are sampled on the falling edge of sys_clk.
// Define LED_SYNC_EN to include the sync_i scenario.
// ----------------------------------------------------------------------------
module tb_led_blink_ctrl;

   localparam int TICK_DIV = 4;
   localparam int NCH      = 8;
   localparam int CNT_W    = 16;
   localparam int PWM_W    = 4;

   logic           sys_clk;
   logic           sys_rst_n;
   logic           tick;
   logic [NCH-1:0] led;
`ifdef LED_SYNC_EN
   logic           sync_i;
`endif

   int checks = 0;
   int errors = 0;
   int cyc;

   led_blink_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

   led_blink_ctrl #(
      .TICK_DIV (TICK_DIV),
      .NCH      (NCH),
      .CNT_W    (CNT_W),
      .PWM_W    (PWM_W)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
`ifdef LED_SYNC_EN
      .sync_i    (sync_i),
`endif
      .cfg       (cfg_if.slave),
      .tick      (tick),
      .led       (led)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Rising edges since the last reset release.
   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) cyc <= 0;
      else            cyc <= cyc + 1;
   end

   task automatic cfg_write(input logic [4:0] ch, input logic [1:0] mode,
                            input logic [CNT_W-1:0] period);
      cfg_if.cfg_we     = 1'b1;
      cfg_if.cfg_ch     = ch;
      cfg_if.cfg_mode   = mode;
      cfg_if.cfg_period = period;
      @(negedge sys_clk);
      cfg_if.cfg_we     = 1'b0;
   endtask

   // Stops at the falling edge where tick is high (bounded).
   task automatic wait_tick();
      bit found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         if (tick === 1'b1) found = 1'b1;
         else @(negedge sys_clk);
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL wait_tick: tick=%b, required a tick within 12 cycles", tick);
      end
   endtask

   task automatic test_reset();
      sys_rst_n = 1'b0;
      cfg_if.cfg_we = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_mode = '0; cfg_if.cfg_period = '0;
`ifdef LED_SYNC_EN
      sync_i = 1'b0;
`endif
      repeat (2) @(negedge sys_clk);
      checks++;
      if (led !== '0 || tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: led=%b tick=%b, required led=0 tick=0", led, tick);
      end
      sys_rst_n = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(negedge sys_clk);
         checks++;
         if (tick !== ((k % 4) == 0) || led !== '0) begin
            errors++;
            $display("FAIL idle_tick cyc %0d: tick=%b led=%b, required tick=%b led=0",
                     k, tick, led, ((k % 4) == 0));
         end
      end
   endtask

   task automatic test_blink();
      logic exp;
      wait_tick();
      @(negedge sys_clk);
      cfg_write(5'd0, 2'b10, 16'd3);
      for (int d = 0; d < 48; d++) begin
         exp = (d >= 12 && d < 24) || (d >= 36);
         checks++;
         if (led[0] !== exp || led[7:1] !== '0) begin
            errors++;
            $display("FAIL blink_p3 d=%0d: led=%b, required led[0]=%b others 0", d, led, exp);
         end
         @(negedge sys_clk);
      end
      cfg_write(5'd0, 2'b00, 16'd0);
   endtask

   task automatic test_pwm();
      int hi;
      logic [CNT_W-1:0] duty [3];
      int               want [3];
      duty[0] = 16'd4;  want[0] = 4;
      duty[1] = 16'd15; want[1] = 15;
      duty[2] = 16'd0;  want[2] = 0;
      for (int t = 0; t < 3; t++) begin
         cfg_write(5'd1, 2'b11, duty[t]);
         repeat (2) @(negedge sys_clk);
         for (int w = 0; w < 2; w++) begin
            hi = 0;
            for (int i = 0; i < 16; i++) begin
               if (led[1] === 1'b1) hi++;
               @(negedge sys_clk);
            end
            checks++;
            if (hi != want[t]) begin
               errors++;
               $display("FAIL pwm_duty %0d window %0d: high=%0d of 16, required %0d",
                        duty[t], w, hi, want[t]);
            end
         end
      end
      cfg_write(5'd1, 2'b00, 16'd0);
      @(negedge sys_clk);
   endtask

   task automatic test_on_range();
      cfg_write(5'd2, 2'b01, 16'd0);
      checks++;
      if (led[2] !== 1'b0) begin
         errors++;
         $display("FAIL on_latency_1: led[2]=%b, required 0", led[2]);
      end
      @(negedge sys_clk);
      checks++;
      if (led[2] !== 1'b1) begin
         errors++;
         $display("FAIL on_latency_2: led[2]=%b, required 1", led[2]);
      end
      cfg_write(5'd9, 2'b00, 16'd0);
      cfg_write(5'd8, 2'b00, 16'd0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (led !== 8'b0000_0100) begin
            errors++;
            $display("FAIL out_of_range %0d: led=%b, required 00000100", i, led);
         end
         @(negedge sys_clk);
      end
      cfg_write(5'd2, 2'b00, 16'd0);
      @(negedge sys_clk);
      checks++;
      if (led[2] !== 1'b0) begin
         errors++;
         $display("FAIL off_write: led[2]=%b, required 0", led[2]);
      end
   endtask

   task automatic test_collision_reset();
      logic exp;
      wait_tick();
      @(negedge sys_clk);
      cfg_write(5'd0, 2'b10, 16'd2);
      wait_tick();
      cfg_write(5'd0, 2'b10, 16'd2);  // lands on the tick edge
      for (int d = 0; d <= 12; d++) begin
         exp = (d >= 9 && d < 17);
         checks++;
         if (led[0] !== exp) begin
            errors++;
            $display("FAIL collision d=%0d: led[0]=%b, required %b", d, led[0], exp);
         end
         if (d < 12) @(negedge sys_clk);
      end
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if (led !== '0 || tick !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: led=%b tick=%b, required led=0 tick=0", led, tick);
      end
      repeat (2) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge sys_clk);
         checks++;
         if (led !== '0 || tick !== (k == 4)) begin
            errors++;
            $display("FAIL post_reset cyc %0d: led=%b tick=%b, required led=0 tick=%b",
                     k, led, tick, (k == 4));
         end
      end
   endtask

`ifdef LED_SYNC_EN
   task automatic test_sync();
      logic exp;
      wait_tick();
      @(negedge sys_clk);
      cfg_write(5'd0, 2'b10, 16'd2);
      wait_tick();
      @(negedge sys_clk);
      cfg_write(5'd1, 2'b10, 16'd2);
      wait_tick();
      repeat (3) @(negedge sys_clk);
      sync_i = 1'b1;                   // edge where tick would have risen
      @(negedge sys_clk);
      sync_i = 1'b0;
      checks++;
      if (tick !== 1'b0) begin
         errors++;
         $display("FAIL sync_tick_suppressed: tick=%b, required 0", tick);
      end
      for (int d = 1; d <= 20; d++) begin
         @(negedge sys_clk);
         exp = (d >= 10 && d < 18);
         checks++;
         if (led[1:0] !== {exp, exp} || tick !== ((d % 4) == 0)) begin
            errors++;
            $display("FAIL sync_align d=%0d: led[1:0]=%b tick=%b, required led=%b%b tick=%b",
                     d, led[1:0], tick, exp, exp, ((d % 4) == 0));
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_blink();
      test_pwm();
      test_on_range();
      test_collision_reset();
`ifdef LED_SYNC_EN
      test_sync();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
